mem_io_ctrl: RTL and testbench

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mem_io_ctrl_if.sv | 15 +
 rtl/mem_io_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_io_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_ctrl_if.sv
// rtl/mem_io_ctrl_if.sv - CPU-side request/response bus of the memory/I-O controller.
interface mem_io_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - Async SRAM sequencer with one memory-mapped switch/hex I/O address.
module mem_io_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter int                WAIT_CYC = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR  = 20'h0FFFF,
    parameter int                NUM_HEX  = 4
) (
    input  logic                 Clk,
    input  logic                 RESET,
    mem_io_ctrl_if.slave         bus,
    output logic                 CE,
    output logic                 OE,
    output logic                 WE,
    output logic                 UB,
    output logic                 LB,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata,
    output logic                 sram_drive,
    input  logic [DATA_W-1:0]    Switches,
    output logic [4*NUM_HEX-1:0] hex_out
);
    localparam int HEX_W = 4 * NUM_HEX;
    localparam int CNT_W = $clog2(WAIT_CYC + 1);

    generate
        if (WAIT_CYC < 1) begin : g_bad_wait
            $error("mem_io_ctrl: WAIT_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic [HEX_W-1:0]  hex_reg;
    logic [HEX_W-1:0]  hex_wdata;

    generate
        if (HEX_W > DATA_W) begin : g_hex_ext
            assign hex_wdata = {{(HEX_W - DATA_W){1'b0}}, bus.wdata};
        end else begin : g_hex_trunc
            assign hex_wdata = bus.wdata[HEX_W-1:0];
        end
    endgenerate

    assign bus.rdata  = rdata_q;
    assign bus.ready  = ready_q;
    assign sram_wdata = wdata_q;
    assign hex_out    = hex_reg;

    // Strobes are registered: each transition loads the values for the state being entered.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            hex_reg    <= '0;
            SRAM_ADDR  <= '0;
            sram_drive <= 1'b0;
            CE         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            UB         <= 1'b1;
            LB         <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.req) begin
                        we_q      <= bus.we;
                        wdata_q   <= bus.wdata;
                        SRAM_ADDR <= bus.addr;
                        if (bus.addr == IO_ADDR) begin
                            state      <= DONE;
                            ready_q    <= 1'b1;
                            CE         <= 1'b1;
                            OE         <= 1'b1;
                            WE         <= 1'b1;
                            UB         <= 1'b1;
                            LB         <= 1'b1;
                            sram_drive <= 1'b0;
                            if (bus.we) hex_reg <= hex_wdata;
                            else        rdata_q <= Switches;
                        end else begin
                            state      <= SETUP;
                            CE         <= 1'b0;
                            UB         <= 1'b0;
                            LB         <= 1'b0;
                            OE         <= bus.we;
                            WE         <= 1'b1;
                            sram_drive <= bus.we;
                        end
                    end else begin
                        state      <= IDLE;
                        CE         <= 1'b1;
                        OE         <= 1'b1;
                        WE         <= 1'b1;
                        UB         <= 1'b1;
                        LB         <= 1'b1;
                        sram_drive <= 1'b0;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= CNT_W'(WAIT_CYC - 1);
                    WE    <= ~we_q;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state      <= DONE;
                        ready_q    <= 1'b1;
                        CE         <= 1'b1;
                        OE         <= 1'b1;
                        WE         <= 1'b1;
                        UB         <= 1'b1;
                        LB         <= 1'b1;
                        sram_drive <= 1'b0;
                        if (!we_q) rdata_q <= sram_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - Scoreboard bench for mem_io_ctrl (WAIT_CYC 2, 1 and 5 builds).
module tb_mem_io_ctrl;
    logic Clk = 1'b0;
    logic RESET = 1'b0;
    always #5 Clk = ~Clk;

    mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(20)) bus ();
    mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(20)) bus1 ();
    mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(20)) bus5 ();

    assign bus1.we    = bus.we;
    assign bus1.addr  = bus.addr;
    assign bus1.wdata = bus.wdata;
    assign bus5.we    = bus.we;
    assign bus5.addr  = bus.addr;
    assign bus5.wdata = bus.wdata;

    logic        CE, OE, WE, UB, LB, sram_drive;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata, hex_out;
    logic [15:0] sram_rd, switches;

    logic        ce1, oe1, we1, ub1, lb1, drv1, ce5, oe5, we5, ub5, lb5, drv5;
    logic [19:0] sa1, sa5;
    logic [15:0] swd1, swd5, hex1, hex5;

    mem_io_ctrl dut (
        .Clk(Clk), .RESET(RESET), .bus(bus.slave),
        .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .SRAM_ADDR(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rd),
        .sram_drive(sram_drive), .Switches(switches), .hex_out(hex_out)
    );

    mem_io_ctrl #(.WAIT_CYC(1)) dut_w1 (
        .Clk(Clk), .RESET(RESET), .bus(bus1.slave),
        .CE(ce1), .OE(oe1), .WE(we1), .UB(ub1), .LB(lb1),
        .SRAM_ADDR(sa1), .sram_wdata(swd1), .sram_rdata(sram_rd),
        .sram_drive(drv1), .Switches(switches), .hex_out(hex1)
    );

    mem_io_ctrl #(.WAIT_CYC(5)) dut_w5 (
        .Clk(Clk), .RESET(RESET), .bus(bus5.slave),
        .CE(ce5), .OE(oe5), .WE(we5), .UB(ub5), .LB(lb5),
        .SRAM_ADDR(sa5), .sram_wdata(swd5), .sram_rdata(sram_rd),
        .sram_drive(drv5), .Switches(switches), .hex_out(hex5)
    );

    typedef struct {
        logic [15:0] rd;
        int          lat;
        int          oe_lo;
        int          we_lo;
        int          drv_hi;
        int          ce_lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic score(input string tag, input logic [15:0] rd, input int lat,
                         input int oe_lo, input int we_lo, input int drv_hi, input int ce_lo);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_rdata"}, rd, e.rd);
        if (e.oe_lo >= 0) begin
            check({tag, "_oe_lo"}, oe_lo, e.oe_lo);
            check({tag, "_we_lo"}, we_lo, e.we_lo);
            check({tag, "_drive"}, drv_hi, e.drv_hi);
            check({tag, "_ce_lo"}, ce_lo, e.ce_lo);
        end
    endtask

    // Called just before a negedge-aligned request; leaves time at the negedge where ready was seen.
    task automatic xfer(input string tag, input logic w, input logic [19:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input int exp_lat, input int exp_oe,
                        input int exp_we, input int exp_drv, input int exp_ce, input bit hold);
        int lat = 0, oe_lo = 0, we_lo = 0, drv_hi = 0, ce_lo = 0;
        bit addr_ok = 1'b1;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        sb.push_back('{exp_rd, exp_lat, exp_oe, exp_we, exp_drv, exp_ce});
        @(posedge Clk);
        #1;
        if (!hold) bus.req = 1'b0;
        if (w) check({tag, "_sram_wdata"}, sram_wdata, d);
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (!OE) oe_lo++;
            if (!WE) we_lo++;
            if (sram_drive) drv_hi++;
            if (!CE) begin
                ce_lo++;
                if (sram_addr !== a || UB || LB) addr_ok = 1'b0;
            end
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
        check({tag, "_addr_ub_lb"}, addr_ok, 1'b1);
        score(tag, bus.rdata, lat, oe_lo, we_lo, drv_hi, ce_lo);
    endtask

    task automatic measure(input string tag, input int sel, input logic [15:0] exp_rd, input int exp_lat);
        int lat = 0;
        logic [15:0] rd = '0;
        bus.we   = 1'b0;
        bus.addr = 20'h00010;
        sb.push_back('{exp_rd, exp_lat, -1, -1, -1, -1});
        if (sel == 1) bus1.req = 1'b1; else bus5.req = 1'b1;
        @(posedge Clk);
        #1;
        bus1.req = 1'b0;
        bus5.req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if ((sel == 1) ? bus1.ready : bus5.ready) begin
                lat = k;
                rd  = (sel == 1) ? bus1.rdata : bus5.rdata;
                break;
            end
        end
        score(tag, rd, lat, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        int ce_low_seen;
        bus.req = 1'b0; bus1.req = 1'b0; bus5.req = 1'b0;
        bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        sram_rd = '0; switches = '0;

        #12;
        check("rst_ready", bus.ready, 1'b0);
        check("rst_strobes", {CE, OE, WE, UB, LB}, 5'h1f);
        check("rst_rdata", bus.rdata, 16'h0);
        check("rst_hex", hex_out, 16'h0);
        check("rst_sram_addr", sram_addr, 20'h0);
        check("rst_drive", sram_drive, 1'b0);
        @(negedge Clk);
        RESET = 1'b1;
        @(negedge Clk);

        sram_rd = 16'hBEEF;
        xfer("rd_10", 1'b0, 20'h00010, 16'h0, 16'hBEEF, 4, 3, 0, 0, 3, 1'b0);
        xfer("wr_20", 1'b1, 20'h00020, 16'h1234, 16'hBEEF, 4, 0, 2, 3, 3, 1'b0);

        switches = 16'h00FF;
        xfer("io_wr", 1'b1, 20'h0FFFF, 16'hA5C3, 16'hBEEF, 1, 0, 0, 0, 0, 1'b0);
        check("io_wr_hex", hex_out, 16'hA5C3);
        xfer("io_rd", 1'b0, 20'h0FFFF, 16'h0, 16'h00FF, 1, 0, 0, 0, 0, 1'b0);
        check("io_rd_hex_hold", hex_out, 16'hA5C3);

        sram_rd = 16'h1111;
        xfer("b2b_a", 1'b0, 20'h00040, 16'h0, 16'h1111, 4, 3, 0, 0, 3, 1'b1);
        sram_rd = 16'h2222;
        xfer("b2b_b", 1'b0, 20'h00044, 16'h0, 16'h2222, 4, 3, 0, 0, 3, 1'b0);

        @(negedge Clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 20'h00030; bus.wdata = 16'h5555;
        @(posedge Clk);
        #1 bus.req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_we_low", WE, 1'b0);
        #2 RESET = 1'b0;
        #1;
        check("abort_async_we_ce", {WE, CE}, 2'b11);
        check("abort_drive", sram_drive, 1'b0);
        check("abort_rdata_clr", bus.rdata, 16'h0);
        @(negedge Clk);
        RESET = 1'b1;
        rdy_seen = 0;
        ce_low_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (bus.ready) rdy_seen++;
            if (!CE) ce_low_seen++;
        end
        check("abort_no_ready", rdy_seen, 0);
        check("abort_idle_ce", ce_low_seen, 0);

        sram_rd = 16'h3C3C;
        xfer("post_rst_rd", 1'b0, 20'h00050, 16'h0, 16'h3C3C, 4, 3, 0, 0, 3, 1'b0);

        @(negedge Clk);
        @(negedge Clk);
        sram_rd = 16'hBEEF;
        measure("w1_rd", 1, 16'hBEEF, 3);
        @(negedge Clk);
        sram_rd = 16'h7E57;
        measure("w5_rd", 5, 16'h7E57, 7);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
